// File: rtl/thiele_lite_exec_core.sv
// Execution core for the simplified Thiele ISA: fetch/exec FSM, internal data memory and
// partition table, mu accounting, EMIT streaming and the final 256-bit state hash.
module thiele_lite_exec_core #(
  parameter int IMEM_AW       = 8,
  parameter int DMEM_AW       = 8,
  parameter int DATA_W        = 32,
  parameter int MAX_MODULES   = 64,
  parameter int MASK_W        = 64,
  parameter int MU_W          = 64,
  parameter int TIMEOUT_STEPS = 10000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               emit_valid,
  input  logic               emit_ready,
  output logic [7:0]         emit_a,
  output logic [7:0]         emit_b,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic [IMEM_AW-1:0] pc,
  output logic [31:0]        step_count,
  output logic [31:0]        num_modules,
  output logic [MU_W-1:0]    mu_discovery,
  output logic [MU_W-1:0]    mu_execution,
  output logic [MU_W-1:0]    mu_total,
  output logic [255:0]       state_hash,
  output logic [2:0]         dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_HASH  = 3'd5;

  localparam int MOD_AW = (MAX_MODULES > 1) ? $clog2(MAX_MODULES) : 1;
  localparam int DMEM_N = 1 << DMEM_AW;

  logic [2:0]         state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [31:0]        step_q, step_d;
  logic [31:0]        nmod_q, nmod_d;
  logic [31:0]        next_id_q, next_id_d;
  logic [MU_W-1:0]    mu_d_q, mu_d_d;
  logic [MU_W-1:0]    mu_e_q, mu_e_d;
  logic               done_q, done_d;
  logic               to_q, to_d;
  logic [7:0]         op_a_q, op_a_d;
  logic [7:0]         op_b_q, op_b_d;
  logic [31:0]        scan_q, scan_d;
  logic [2:0]         hidx_q, hidx_d;
  logic [255:0]       hash_q, hash_d;
  logic [DATA_W-1:0]  dmem_q [DMEM_N];
  logic [DATA_W-1:0]  dmem_d [DMEM_N];
  logic [MASK_W-1:0]  mask_q [MAX_MODULES];
  logic [MASK_W-1:0]  mask_d [MAX_MODULES];

  logic [7:0]         ex_op, ex_a, ex_b;
  logic [DMEM_AW-1:0] da, db;
  logic [MASK_W-1:0]  scan_mask;
  logic [MU_W-1:0]    mu_sum;
  logic [31:0]        hash_word;
  logic               retire;
  logic               unused_rdata;

  assign ex_op        = imem_rdata[31:24];
  assign ex_a         = imem_rdata[23:16];
  assign ex_b         = imem_rdata[15:8];
  assign unused_rdata = ^imem_rdata[7:0];
  assign da           = DMEM_AW'(ex_a);
  assign db           = DMEM_AW'(ex_b);
  assign scan_mask    = MASK_W'(1) << op_a_q;
  assign mu_sum       = mu_d_q + mu_e_q;

  function automatic logic [31:0] xorshift(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  always_comb begin
    hash_word = '0;
    case (hidx_q)
      3'd0: hash_word = 32'(pc_q) ^ next_id_q;
      3'd1: hash_word = nmod_q ^ step_q;
      3'd2: hash_word = mu_d_q[31:0] ^ mu_e_q[31:0];
      3'd3: hash_word = mu_sum[31:0];
      3'd4: hash_word = mask_q[0][31:0];
      3'd5: hash_word = mask_q[1][31:0];
      3'd6: hash_word = dmem_q[0][31:0];
      default: hash_word = dmem_q[1][31:0];
    endcase
  end

  // EMIT handshake: emit_valid rises once an EMIT is decoded and stays high with emit_a/emit_b
  // stable until a cycle in which emit_ready is also high; that cycle is the single transfer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    step_d    = step_q;
    nmod_d    = nmod_q;
    next_id_d = next_id_q;
    mu_d_d    = mu_d_q;
    mu_e_d    = mu_e_q;
    done_d    = done_q;
    to_d      = to_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    scan_d    = scan_q;
    hidx_d    = hidx_q;
    hash_d    = hash_q;
    dmem_d    = dmem_q;
    mask_d    = mask_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          step_d    = '0;
          nmod_d    = 32'd1;
          next_id_d = 32'd1;
          mu_d_d    = MU_W'(1);
          mu_e_d    = '0;
          done_d    = 1'b0;
          to_d      = 1'b0;
          hash_d    = '0;
          for (int i = 0; i < DMEM_N; i++) dmem_d[i] = '0;
          for (int i = 0; i < MAX_MODULES; i++) mask_d[i] = '0;
          mask_d[0] = MASK_W'(1);
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        op_a_d = ex_a;
        op_b_d = ex_b;
        case (ex_op)
          8'h00: begin
            if ({24'd0, ex_a} < 32'(MASK_W)) begin
              state_d = S_SCAN;
              scan_d  = '0;
            end else begin
              retire = 1'b1;
            end
          end
          8'h0A: begin
            dmem_d[da] = DATA_W'(ex_b);
            mu_e_d     = mu_e_q + MU_W'(1);
            retire     = 1'b1;
          end
          8'h0B: begin
            dmem_d[da] = dmem_q[da] ^ dmem_q[db];
            mu_e_d     = mu_e_q + MU_W'(1);
            retire     = 1'b1;
          end
          8'h0C: begin
            // With da==db the second write restores the original word.
            dmem_d[da] = dmem_q[db];
            dmem_d[db] = dmem_q[da];
            mu_e_d     = mu_e_q + MU_W'(3);
            retire     = 1'b1;
          end
          8'h0E: state_d = S_EMIT;
          8'hFF: begin
            state_d = S_HASH;
            hidx_d  = '0;
          end
          default: retire = 1'b1;
        endcase
      end
      S_SCAN: begin
        if (mask_q[scan_q[MOD_AW-1:0]] == scan_mask) begin
          retire = 1'b1;
        end else if (scan_q + 32'd1 == nmod_q) begin
          if (nmod_q < 32'(MAX_MODULES)) begin
            mask_d[nmod_q[MOD_AW-1:0]] = scan_mask;
            nmod_d    = nmod_q + 32'd1;
            next_id_d = next_id_q + 32'd1;
            mu_d_d    = mu_d_q + MU_W'(1);
          end
          retire = 1'b1;
        end else begin
          scan_d = scan_q + 32'd1;
        end
      end
      S_EMIT: if (emit_ready) retire = 1'b1;
      S_HASH: begin
        hash_d[{hidx_q, 5'd0} +: 32] = xorshift(hash_word);
        if (hidx_q == 3'd7) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          hidx_d = hidx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (retire) begin
      pc_d   = pc_q + 1'b1;
      step_d = step_q + 32'd1;
      if (step_d == 32'(TIMEOUT_STEPS)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        to_d    = 1'b1;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      step_q    <= '0;
      nmod_q    <= '0;
      next_id_q <= '0;
      mu_d_q    <= '0;
      mu_e_q    <= '0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      scan_q    <= '0;
      hidx_q    <= '0;
      hash_q    <= '0;
      for (int i = 0; i < DMEM_N; i++) dmem_q[i] <= '0;
      for (int i = 0; i < MAX_MODULES; i++) mask_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      step_q    <= step_d;
      nmod_q    <= nmod_d;
      next_id_q <= next_id_d;
      mu_d_q    <= mu_d_d;
      mu_e_q    <= mu_e_d;
      done_q    <= done_d;
      to_q      <= to_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      scan_q    <= scan_d;
      hidx_q    <= hidx_d;
      hash_q    <= hash_d;
      dmem_q    <= dmem_d;
      mask_q    <= mask_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign emit_valid   = (state_q == S_EMIT);
  assign emit_a       = op_a_q;
  assign emit_b       = op_b_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign timed_out    = to_q;
  assign step_count   = step_q;
  assign num_modules  = nmod_q;
  assign mu_discovery = mu_d_q;
  assign mu_execution = mu_e_q;
  assign mu_total     = mu_sum;
  assign state_hash   = (done_q && !to_q) ? hash_q : '0;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_thiele_lite_exec_core.sv
// Bench for thiele_lite_exec_core: directed programs plus random programs scored against a
// program-level reference interpreter.
`timescale 1ns/1ps
module tb_thiele_lite_exec_core;
  localparam int TO   = 16;
  localparam int MAXM = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   imem_addr;
  logic [31:0]  imem_rdata = '0;
  logic         emit_valid;
  logic         emit_ready = 1'b0;
  logic [7:0]   emit_a, emit_b;
  logic         busy, done, timed_out;
  logic [7:0]   pc;
  logic [31:0]  step_count, num_modules;
  logic [63:0]  mu_discovery, mu_execution, mu_total;
  logic [255:0] state_hash;
  logic [2:0]   dbg_state;

  thiele_lite_exec_core #(.MAX_MODULES(MAXM), .TIMEOUT_STEPS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .emit_valid(emit_valid), .emit_ready(emit_ready), .emit_a(emit_a), .emit_b(emit_b),
    .busy(busy), .done(done), .timed_out(timed_out), .pc(pc), .step_count(step_count),
    .num_modules(num_modules), .mu_discovery(mu_discovery), .mu_execution(mu_execution),
    .mu_total(mu_total), .state_hash(state_hash), .dbg_state(dbg_state)
  );

  // ---------------- clock / ROM ----------------
  always #5 clk = ~clk;
  logic [31:0] rom [256];
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [7:0]   pc;
    logic [31:0]  step;
    logic [31:0]  nmod;
    logic [63:0]  md;
    logic [63:0]  me;
    logic         to;
    logic [255:0] hash;
  } run_t;

  run_t        run_exp_q[$];
  logic [15:0] emit_exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_mode = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Reference interpreter: runs the whole program from rom[] and queues the expected results.
  task automatic model_run();
    logic [31:0] dm [256];
    logic [63:0] masks[$];
    logic [7:0]  p, op, a, b;
    logic [31:0] stp, ins, t, nm, w;
    logic [63:0] md, me, m, mt, m1;
    logic        halted, found;
    run_t        r;
    for (int i = 0; i < 256; i++) dm[i] = '0;
    masks.push_back(64'd1);
    p = 0; stp = 0; md = 1; me = 0; halted = 0;
    for (int n = 0; n < TO; n++) begin
      ins = rom[p]; op = ins[31:24]; a = ins[23:16]; b = ins[15:8];
      if (op == 8'hFF) begin
        halted = 1;
        break;
      end
      case (op)
        8'h00: if (a < 64) begin
          m = 64'd1 << a;
          found = 0;
          foreach (masks[k]) if (masks[k] == m) found = 1;
          if (!found && masks.size() < MAXM) begin
            masks.push_back(m);
            md = md + 1;
          end
        end
        8'h0A: begin dm[a] = {24'd0, b}; me = me + 1; end
        8'h0B: begin dm[a] = dm[a] ^ dm[b]; me = me + 1; end
        8'h0C: begin t = dm[a]; dm[a] = dm[b]; dm[b] = t; me = me + 3; end
        8'h0E: emit_exp_q.push_back({a, b});
        default: ;
      endcase
      p = p + 8'd1;
      stp = stp + 1;
    end
    nm = masks.size();
    mt = md + me;
    r.pc = p; r.step = stp; r.nmod = nm; r.md = md; r.me = me; r.to = !halted;
    r.hash = '0;
    if (halted) begin
      m1 = (masks.size() > 1) ? masks[1] : 64'd0;
      for (int i = 0; i < 8; i++) begin
        case (i)
          0: w = {24'd0, p} ^ nm;
          1: w = nm ^ stp;
          2: w = md[31:0] ^ me[31:0];
          3: w = mt[31:0];
          4: w = masks[0][31:0];
          5: w = m1[31:0];
          6: w = dm[0];
          default: w = dm[1];
        endcase
        r.hash[i*32 +: 32] = xs(w);
      end
    end
    run_exp_q.push_back(r);
  endtask

  // ---------------- monitor ----------------
  logic        done_prev = 1'b0;
  logic        held_flag = 1'b0;
  logic [15:0] held_ab = '0;
  logic [15:0] exp_ab;
  run_t        mon_r;

  always @(negedge clk) begin
    if (held_flag) begin
      check("emit_valid_held", emit_valid, 1'b1);
      check("emit_ab_held", {emit_a, emit_b}, held_ab);
    end
    held_flag = emit_valid && !emit_ready;
    held_ab   = {emit_a, emit_b};
    if (emit_valid && emit_ready) begin
      if (emit_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL emit_unexpected actual=%0h expected=none", {emit_a, emit_b});
      end else begin
        exp_ab = emit_exp_q.pop_front();
        check("emit_ab", {emit_a, emit_b}, exp_ab);
      end
    end
    if (done && !done_prev) begin
      if (run_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done_unexpected actual=1 expected=no_run_pending");
      end else begin
        mon_r = run_exp_q.pop_front();
        check("pc", pc, mon_r.pc);
        check("step_count", step_count, mon_r.step);
        check("num_modules", num_modules, mon_r.nmod);
        check("mu_discovery", mu_discovery, mon_r.md);
        check("mu_execution", mu_execution, mon_r.me);
        check("mu_total", mu_total, mon_r.md + mon_r.me);
        check("timed_out", timed_out, mon_r.to);
        check("state_hash", state_hash, mon_r.hash);
        check("busy_at_done", busy, 1'b0);
      end
    end
    done_prev = done;
  end

  // ---------------- drivers ----------------
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: emit_ready = 1'($urandom_range(0, 1));
      1: emit_ready = 1'b0;
      default: emit_ready = 1'b1;
    endcase
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s_no_done actual=busy expected=done", name);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_exp_q.delete();
      emit_exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_prog(input string name);
    model_run();
    pulse_start();
    wait_done(name);
  endtask

  task automatic fill_rom(input logic [31:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [7:0] op, a, b;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: op = 8'h00;
      3, 8:    op = 8'h0A;
      4, 9:    op = 8'h0B;
      5:       op = 8'h0C;
      6:       op = 8'h0E;
      default: op = 8'h33;
    endcase
    if (op == 8'h00)
      a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(60, 80)) : 8'($urandom_range(0, 7));
    else
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
    b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
    return {op, a, b, 8'($urandom_range(0, 255))};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    bit do_halt;
    fill_rom(32'h0);
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timed_out", timed_out, 1'b0);
    check("rst_pc", pc, 8'd0);
    check("rst_imem_addr", imem_addr, 8'd0);
    check("rst_step", step_count, 32'd0);
    check("rst_num_modules", num_modules, 32'd0);
    check("rst_mu_disc", mu_discovery, 64'd0);
    check("rst_mu_exec", mu_execution, 64'd0);
    check("rst_mu_total", mu_total, 64'd0);
    check("rst_hash", state_hash, 256'd0);
    check("rst_emit_valid", emit_valid, 1'b0);
    ready_mode = 0;

    // T1
    fill_rom(32'h0);
    rom[0] = 32'h0A000700; rom[1] = 32'h0A010300; rom[2] = 32'h0B000100; rom[3] = 32'hFF000000;
    run_prog("t1");
    check("t1_done", done, 1'b1);
    check("t1_pc", pc, 8'd3);
    check("t1_step", step_count, 32'd3);
    check("t1_mu_exec", mu_execution, 64'd3);
    check("t1_mu_disc", mu_discovery, 64'd1);
    check("t1_mu_total", mu_total, 64'd4);

    // T2
    rom[0] = 32'h00000000; rom[1] = 32'h00050000; rom[2] = 32'h00050000; rom[3] = 32'hFF000000;
    run_prog("t2");
    check("t2_num_modules", num_modules, 32'd2);
    check("t2_mu_disc", mu_discovery, 64'd2);
    check("t2_step", step_count, 32'd3);

    // T3: EMIT held under back-pressure, then one transfer
    rom[0] = 32'h0E010200; rom[1] = 32'hFF000000;
    ready_mode = 1;
    model_run();
    pulse_start();
    repeat (7) @(negedge clk);
    check("t3_emit_valid", emit_valid, 1'b1);
    check("t3_emit_ab", {emit_a, emit_b}, 16'h0102);
    check("t3_pc_stalled", pc, 8'd0);
    ready_mode = 2;
    wait_done("t3");
    check("t3_pc", pc, 8'd1);
    check("t3_emit_left", emit_exp_q.size(), 0);
    ready_mode = 0;

    // T4
    rom[0] = 32'h0A020900; rom[1] = 32'h0C020200; rom[2] = 32'h0C020300; rom[3] = 32'hFF000000;
    run_prog("t4");
    check("t4_mu_exec", mu_execution, 64'd7);

    // T5: timeout
    fill_rom(32'h0B000100);
    run_prog("t5");
    check("t5_done", done, 1'b1);
    check("t5_timed_out", timed_out, 1'b1);
    check("t5_step", step_count, 32'd16);
    check("t5_hash", state_hash, 256'd0);

    // T6: reset mid-SCAN, then rerun T2 with a stray start while busy
    fill_rom(32'h0);
    rom[0] = 32'h00000000; rom[1] = 32'h00050000; rom[2] = 32'h00050000; rom[3] = 32'hFF000000;
    pulse_start();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_nmod", num_modules, 32'd0);
    model_run();
    pulse_start();
    repeat (3) @(negedge clk);
    check("t6_busy", busy, 1'b1);
    pulse_start();
    wait_done("t6");
    check("t6_num_modules", num_modules, 32'd2);
    check("t6_mu_disc", mu_discovery, 64'd2);

    // Random programs
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 256; i++) rom[i] = rand_instr();
      len = $urandom_range(0, 14);
      do_halt = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < len; i++) rom[i] = rand_instr();
      if (do_halt) rom[len] = 32'hFF000000;
      run_prog("rand");
    end

    check("end_emit_q_empty", emit_exp_q.size(), 0);
    check("end_run_q_empty", run_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
